// File: rtl/fft_io_buffer.sv
// Input/output sequencer for an in-place radix-2 FFT.
// Loads N samples into the shared RAM in bit-reversed order, kicks the address
// controller, waits for it to finish, then streams the results out in natural order.
module fft_io_buffer #(
  parameter int unsigned N     = 8,
  parameter int unsigned L_max = 3,
  parameter int unsigned DW    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // Input stream
  input  logic                 din_valid_i,
  output logic                 din_ready_o,
  input  logic [DW-1:0]        din_re_i,
  input  logic [DW-1:0]        din_im_i,
  // RAM write port
  output logic                 ram_we_o,
  output logic [L_max-1:0]     ram_waddr_o,
  output logic [DW-1:0]        ram_wdata_re_o,
  output logic [DW-1:0]        ram_wdata_im_o,
  // RAM read port
  output logic                 ram_re_o,
  output logic [L_max-1:0]     ram_raddr_o,
  input  logic [DW-1:0]        ram_rdata_re_i,
  input  logic [DW-1:0]        ram_rdata_im_i,
  // Address controller handshake
  output logic                 initial_flag_o,
  input  logic                 fft_finish_i,
  output logic                 busy_fft_o,
  // Output stream
  output logic                 dout_valid_o,
  output logic [DW-1:0]        dout_re_o,
  output logic [DW-1:0]        dout_im_o,
  output logic                 dout_last_o
);

  localparam logic [L_max-1:0] LastIdx = L_max'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitFft,
    StUnload
  } state_e;

  state_e           state_q;
  logic [L_max-1:0] in_cnt_q;
  logic [L_max-1:0] in_cnt_rev;
  logic             fin_q;

  // Read issued last cycle: RAM data is on ram_rdata_* this cycle
  logic             rd_pend_q;
  logic             rd_last_q;

  logic             ram_we_q;
  logic [L_max-1:0] ram_waddr_q;
  logic [DW-1:0]    ram_wdata_re_q;
  logic [DW-1:0]    ram_wdata_im_q;
  logic             ram_re_q;
  logic [L_max-1:0] ram_raddr_q;
  logic             initial_flag_q;
  logic             busy_q;
  logic             dout_valid_q;
  logic [DW-1:0]    dout_re_q;
  logic [DW-1:0]    dout_im_q;
  logic             dout_last_q;

  // Bit-reversed write address for the current input index
  assign in_cnt_rev = {<<{in_cnt_q}};

  // Sequencer FSM with registered RAM, handshake and output-stream signals
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      in_cnt_q       <= '0;
      fin_q          <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_last_q      <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_waddr_q    <= '0;
      ram_wdata_re_q <= '0;
      ram_wdata_im_q <= '0;
      ram_re_q       <= 1'b0;
      ram_raddr_q    <= '0;
      initial_flag_q <= 1'b0;
      busy_q         <= 1'b0;
      dout_valid_q   <= 1'b0;
      dout_re_q      <= '0;
      dout_im_q      <= '0;
      dout_last_q    <= 1'b0;
    end else begin
      fin_q          <= fft_finish_i;
      ram_we_q       <= 1'b0;
      ram_re_q       <= 1'b0;
      initial_flag_q <= 1'b0;

      // Two-stage read pipeline: RAM latency, then output register
      rd_pend_q      <= ram_re_q;
      rd_last_q      <= ram_re_q && (ram_raddr_q == LastIdx);
      dout_valid_q   <= rd_pend_q;
      dout_last_q    <= rd_last_q;
      if (rd_pend_q) begin
        dout_re_q <= ram_rdata_re_i;
        dout_im_q <= ram_rdata_im_i;
      end

      case (state_q)
        StIdle: begin
          state_q <= StLoad;
        end
        StLoad: begin
          if (din_valid_i) begin
            ram_we_q       <= 1'b1;
            ram_waddr_q    <= in_cnt_rev;
            ram_wdata_re_q <= din_re_i;
            ram_wdata_im_q <= din_im_i;
            if (in_cnt_q == LastIdx) begin
              // Flag shares the cycle with the last write so the write lands
              // on the same edge the controller samples the start pulse
              in_cnt_q       <= '0;
              state_q        <= StStart;
              initial_flag_q <= 1'b1;
              busy_q         <= 1'b1;
            end else begin
              in_cnt_q <= in_cnt_q + 1'b1;
            end
          end
        end
        StStart: begin
          state_q <= StWaitFft;
        end
        StWaitFft: begin
          // Rising edge only, so a level left high from a prior run is ignored
          if (fft_finish_i && !fin_q) begin
            state_q     <= StUnload;
            busy_q      <= 1'b0;
            ram_re_q    <= 1'b1;
            ram_raddr_q <= '0;
          end
        end
        StUnload: begin
          if (ram_raddr_q == LastIdx) begin
            state_q     <= StLoad;
            ram_raddr_q <= '0;
          end else begin
            ram_re_q    <= 1'b1;
            ram_raddr_q <= ram_raddr_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign din_ready_o    = (state_q == StLoad);
  assign ram_we_o       = ram_we_q;
  assign ram_waddr_o    = ram_waddr_q;
  assign ram_wdata_re_o = ram_wdata_re_q;
  assign ram_wdata_im_o = ram_wdata_im_q;
  assign ram_re_o       = ram_re_q;
  assign ram_raddr_o    = ram_raddr_q;
  assign initial_flag_o = initial_flag_q;
  assign busy_fft_o     = busy_q;
  assign dout_valid_o   = dout_valid_q;
  assign dout_re_o      = dout_re_q;
  assign dout_im_o      = dout_im_q;
  assign dout_last_o    = dout_last_q;

endmodule

// File: tb/tb_fft_io_buffer.sv
// Bench for fft_io_buffer: scoreboarded RAM writes and output samples plus
// directed timing checks of the load/start/wait/unload sequence.
module tb_fft_io_buffer;

  localparam int unsigned N     = 8;
  localparam int unsigned L_max = 3;
  localparam int unsigned DW    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [DW-1:0]    din_re = '0;
  logic [DW-1:0]    din_im = '0;
  logic             ram_we;
  logic [L_max-1:0] ram_waddr;
  logic [DW-1:0]    ram_wdata_re;
  logic [DW-1:0]    ram_wdata_im;
  logic             ram_re;
  logic [L_max-1:0] ram_raddr;
  logic [DW-1:0]    ram_rdata_re = '0;
  logic [DW-1:0]    ram_rdata_im = '0;
  logic             initial_flag;
  logic             fft_finish = 1'b0;
  logic             busy_fft;
  logic             dout_valid;
  logic [DW-1:0]    dout_re;
  logic [DW-1:0]    dout_im;
  logic             dout_last;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [L_max-1:0] a;
    logic [DW-1:0]    re;
    logic [DW-1:0]    im;
  } wr_t;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } rd_t;

  wr_t wq[$];
  rd_t rq[$];
  wr_t mon_w;
  rd_t mon_r;

  logic [L_max-1:0] exp_addr [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  fft_io_buffer #(.N(N), .L_max(L_max), .DW(DW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .din_valid_i    (din_valid),
    .din_ready_o    (din_ready),
    .din_re_i       (din_re),
    .din_im_i       (din_im),
    .ram_we_o       (ram_we),
    .ram_waddr_o    (ram_waddr),
    .ram_wdata_re_o (ram_wdata_re),
    .ram_wdata_im_o (ram_wdata_im),
    .ram_re_o       (ram_re),
    .ram_raddr_o    (ram_raddr),
    .ram_rdata_re_i (ram_rdata_re),
    .ram_rdata_im_i (ram_rdata_im),
    .initial_flag_o (initial_flag),
    .fft_finish_i   (fft_finish),
    .busy_fft_o     (busy_fft),
    .dout_valid_o   (dout_valid),
    .dout_re_o      (dout_re),
    .dout_im_o      (dout_im),
    .dout_last_o    (dout_last)
  );

  always #5 clk = ~clk;

  // RAM model holding FFT results: data[k] = 100+k (re), 200+k (im), 1-cycle read
  always @(posedge clk) begin
    if (ram_re) begin
      ram_rdata_re <= 16'(100 + int'(ram_raddr));
      ram_rdata_im <= 16'(200 + int'(ram_raddr));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor for RAM writes and output samples
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        if (wq.size() == 0) begin
          check("extra_write", 64'(ram_we), 64'd0);
        end else begin
          mon_w = wq.pop_front();
          check("write", {ram_waddr, ram_wdata_re, ram_wdata_im}, mon_w);
        end
      end else if (wq.size() != 0) begin
        check("write_missing", 64'(ram_we), 64'd1);
        void'(wq.pop_front());
      end
      if (dout_valid) begin
        if (rq.size() == 0) begin
          check("extra_dout", 64'(dout_valid), 64'd0);
        end else begin
          mon_r = rq.pop_front();
          check("dout", {dout_re, dout_im, dout_last}, mon_r);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {din_ready, ram_we, ram_waddr, ram_re, ram_raddr, initial_flag,
                          busy_fft, dout_valid, dout_last}, 64'd0);
    check({tag, "_data"}, {ram_wdata_re, ram_wdata_im, dout_re, dout_im}, 64'd0);
  endtask

  // Asynchronous reset issued between clock edges, released one cycle later
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_zero("reset_async");
    wq.delete();
    rq.delete();
    din_valid = 1'b0;
    @(negedge clk);
    check_zero("reset_hold");
    #2 rst = 1'b0;
    #1 check("ready_in_idle", 64'(din_ready), 64'd0);
    @(negedge clk);
    check("ready_after_reset", 64'(din_ready), 64'd1);
  endtask

  task automatic load_frame(input int count, input bit gaps, input logic [DW-1:0] base,
                            input logic [DW-1:0] im_xor);
    int   idx = 0;
    int   cyc = 0;
    logic rdy;
    logic v;
    while (idx < count && cyc < 40) begin
      @(negedge clk);
      check("no_early_flag", 64'(initial_flag), 64'd0);
      rdy       = din_ready;
      v         = gaps ? (cyc % 2 == 0) : 1'b1;
      din_valid = v;
      din_re    = 16'(base + 16'(idx));
      din_im    = 16'(base + 16'(idx)) ^ im_xor;
      @(posedge clk);
      if (v && rdy) begin
        wq.push_back('{a: exp_addr[idx], re: 16'(base + 16'(idx)),
                       im: 16'(base + 16'(idx)) ^ im_xor});
        idx++;
      end
      cyc++;
    end
    check("load_count", 64'(idx), 64'(count));
    check("load_cycles", 64'(cyc), gaps ? 64'(2 * count - 1) : 64'(count));
    @(negedge clk);
    din_valid = 1'b0;
    if (count == int'(N)) begin
      // Last write and start pulse share this cycle
      check("start_flag", {initial_flag, din_ready, busy_fft}, 3'b101);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        din_valid = i[0];
        check("start_after", {initial_flag, din_ready, busy_fft, ram_re}, 4'b0010);
      end
      din_valid = 1'b0;
    end
  endtask

  task automatic do_unload(input bit hold);
    for (int k = 0; k < int'(N); k++) begin
      rq.push_back('{re: 16'(100 + k), im: 16'(200 + k), last: (k == int'(N) - 1)});
    end
    @(negedge clk);
    fft_finish = 1'b1;
    @(negedge clk);
    if (!hold) fft_finish = 1'b0;
    check("unload_start", {busy_fft, ram_re, ram_raddr}, {1'b0, 1'b1, 3'd0});
    for (int k = 1; k < int'(N); k++) begin
      @(negedge clk);
      check("read_addr", {ram_re, ram_raddr}, {1'b1, 3'(k)});
      if (k <= 2) check("dout_latency", 64'(dout_valid), 64'(k == 2));
    end
    @(negedge clk);
    check("unload_end", {ram_re, din_ready}, 2'b01);
    @(negedge clk);
    @(negedge clk);
    check("drain_idle", {ram_re, dout_valid}, 2'b00);
    check("drain_count", 64'(rq.size()), 64'd0);
    if (hold) begin
      repeat (3) begin
        @(negedge clk);
        check("no_retrigger", 64'(ram_re), 64'd0);
      end
      fft_finish = 1'b0;
    end
  endtask

  initial begin
    // Power-on reset
    @(negedge clk);
    do_reset();

    // Continuous load, then unload 20 cycles after the start pulse
    load_frame(8, 1'b0, 16'd0, 16'd0);
    repeat (16) begin
      @(negedge clk);
      check("wait_fft", {busy_fft, ram_re, din_ready}, 3'b100);
    end
    do_unload(1'b0);

    // Gapped input, valid toggled while not ready
    load_frame(8, 1'b1, 16'h0040, 16'h5a5a);
    do_unload(1'b0);

    // Stale finish level held from before the start pulse
    fft_finish = 1'b1;
    load_frame(8, 1'b0, 16'h0300, 16'h00ff);
    repeat (10) begin
      @(negedge clk);
      check("stale_hold", {busy_fft, ram_re}, 2'b10);
    end
    @(negedge clk);
    fft_finish = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stale_low", {busy_fft, ram_re}, 2'b10);
    end
    do_unload(1'b1);

    // Reset after 5 accepted samples
    load_frame(5, 1'b0, 16'h0700, 16'h0f0f);
    do_reset();
    load_frame(8, 1'b0, 16'h0800, 16'h1111);

    // Reset during unload after 3 reads
    rq.push_back('{re: 16'd100, im: 16'd200, last: 1'b0});
    @(negedge clk);
    fft_finish = 1'b1;
    @(negedge clk);
    fft_finish = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_unload_reads", {ram_re, ram_raddr}, {1'b1, 3'd2});
    do_reset();

    // Recovery: full frame after the mid-unload reset
    load_frame(8, 1'b0, 16'h0900, 16'h2222);
    do_unload(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
